// File: rtl/hamming_req_arbiter.sv
// hamming_req_arbiter: round-robin encode/decode arbiter over one shared Hamming(7,4) datapath.
// Define HAMMING_ERR_INJECT_EN to add inj_en/inj_pos single-bit fault injection on encode results.
module hamming_req_arbiter #(
  parameter int ERR_CNT_W = 8,
  parameter bit DEC_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enc_valid,
  input  logic [3:0]           enc_data,
  output logic                 enc_ready,
  input  logic                 dec_valid,
  input  logic [6:0]           dec_code,
  output logic                 dec_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [6:0]           res_data,
  output logic                 res_tag,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic                 inj_en,
  input  logic [2:0]           inj_pos,
`endif
  output logic                 busy,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count
);
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  state_t state, state_nxt;
  logic rr_ptr, op_tag, grant_dec, accept;
  logic [6:0] op, enc_word, dec_fixed, flip, inj_mask, result;
  logic [2:0] syn;
  assign grant_dec = dec_valid && (!enc_valid || rr_ptr);
  assign accept = state == IDLE && (enc_valid || dec_valid);
  assign enc_ready = state == IDLE && enc_valid && !grant_dec;
  assign dec_ready = state == IDLE && grant_dec;
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (accept ? EXEC : IDLE) :
                state == EXEC ? HOLD :
                (res_valid && res_ready ? IDLE : HOLD);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // Encode operands occupy op[3:0]; decode operands use the full codeword.
  assign enc_word = {op[3], op[2], op[1], op[1] ^ op[2] ^ op[3], op[0], op[0] ^ op[2] ^ op[3], op[0] ^ op[1] ^ op[3]};
  assign syn = {op[3] ^ op[4] ^ op[5] ^ op[6], op[1] ^ op[2] ^ op[5] ^ op[6], op[0] ^ op[2] ^ op[4] ^ op[6]};
  assign flip = 7'((8'd1 << syn) >> 1);
  assign dec_fixed = op ^ flip;
  assign result = op_tag ? {syn, dec_fixed[6], dec_fixed[5], dec_fixed[4], dec_fixed[2]} : enc_word ^ inj_mask;
`ifdef HAMMING_ERR_INJECT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) inj_mask <= '0;
    else if (accept) inj_mask <= (!grant_dec && inj_en) ? 7'((8'd1 << inj_pos) >> 1) : '0;
`else
  assign inj_mask = '0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= DEC_FIRST;
      op <= '0;
      op_tag <= 1'b0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_tag <= 1'b0;
    end else begin
      if (accept) begin
        op <= grant_dec ? dec_code : {3'b000, enc_data};
        op_tag <= grant_dec;
        rr_ptr <= !grant_dec;
      end
      if (state == EXEC) begin
        res_valid <= 1'b1;
        res_data <= result;
        res_tag <= op_tag;
      end else if (state == HOLD && res_ready) res_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) err_count <= '0;
    else if (err_clr) err_count <= '0;
    else if (state == EXEC && op_tag && syn != 3'd0 && err_count != '1) err_count <= err_count + 1'b1;
endmodule

// File: tb/tb_hamming_req_arbiter.sv
// tb_hamming_req_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_hamming_req_arbiter;
  localparam int W = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enc_valid = 1'b0, dec_valid = 1'b0, res_ready = 1'b0, err_clr = 1'b0;
  logic [3:0] enc_data = '0;
  logic [6:0] dec_code = '0;
  logic enc_ready, dec_ready, res_valid, res_tag, busy;
  logic [6:0] res_data;
  logic [W-1:0] err_count;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  hamming_req_arbiter #(.ERR_CNT_W(W), .DEC_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst),
    .enc_valid(enc_valid), .enc_data(enc_data), .enc_ready(enc_ready),
    .dec_valid(dec_valid), .dec_code(dec_code), .dec_ready(dec_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
`ifdef HAMMING_ERR_INJECT_EN
    .inj_en(1'b0), .inj_pos(3'd0),
`endif
    .busy(busy), .err_clr(err_clr), .err_count(err_count)
  );
  // Syndrome as the XOR of the 1-based positions of all set bits.
  function automatic logic [2:0] syn_of(input logic [6:0] c);
    logic [2:0] s = '0;
    for (int i = 0; i < 7; i++) if (c[i]) s ^= 3'(i + 1);
    return s;
  endfunction
  function automatic logic [6:0] enc_of(input logic [3:0] d);
    logic [6:0] c = '0;
    logic [2:0] s;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    s = syn_of(c);
    c[0] = s[0]; c[1] = s[1]; c[3] = s[2];
    return c;
  endfunction
  function automatic logic [6:0] dec_ref(input logic [6:0] c);
    logic [6:0] w = c;
    logic [2:0] s = syn_of(c);
    if (s != 3'd0) w[s - 1] = ~w[s - 1];
    return {s, w[6], w[5], w[4], w[2]};
  endfunction
  task automatic do_reset;
    rst = 1'b1; enc_valid = 1'b0; dec_valid = 1'b0; res_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1; enc_valid = 1'b0; dec_valid = 1'b0; res_ready = 1'b0; err_clr = 1'b0;
    #1;
    checks++; if ({enc_ready, dec_ready, res_valid, res_tag, busy} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b required 00000", {enc_ready, dec_ready, res_valid, res_tag, busy}); end
    checks++; if (res_data !== 7'h00) begin errors++; $display("FAIL reset_data: got %h required 00", res_data); end
    checks++; if (err_count !== '0) begin errors++; $display("FAIL reset_err: got %0d required 0", err_count); end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_encode;
    enc_data = 4'b1011; enc_valid = 1'b1; res_ready = 1'b1;
    #1;
    checks++; if ({enc_ready, dec_ready} !== 2'b10) begin errors++; $display("FAIL enc_accept: readies %b required 10", {enc_ready, dec_ready}); end
    @(negedge clk);
    enc_valid = 1'b0;
    #1;
    checks++; if ({busy, res_valid} !== 2'b10) begin errors++; $display("FAIL enc_exec: busy,res_valid %b required 10", {busy, res_valid}); end
    @(negedge clk);
    checks++; if ({res_valid, res_tag, res_data} !== {2'b10, 7'h55}) begin errors++; $display("FAIL enc_result: valid %b tag %b data %h required 1 0 55", res_valid, res_tag, res_data); end
    checks++; if (err_count !== '0) begin errors++; $display("FAIL enc_err: got %0d required 0", err_count); end
    @(negedge clk);
    checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL enc_return: res_valid,busy %b required 00", {res_valid, busy}); end
  endtask
  task automatic test_decode;
    dec_code = 7'h51; dec_valid = 1'b1; res_ready = 1'b1;
    #1;
    checks++; if ({enc_ready, dec_ready} !== 2'b01) begin errors++; $display("FAIL dec_accept: readies %b required 01", {enc_ready, dec_ready}); end
    @(negedge clk);
    dec_valid = 1'b0;
    @(negedge clk);
    checks++; if ({res_valid, res_tag, res_data} !== {2'b11, 7'h3B}) begin errors++; $display("FAIL dec_result: valid %b tag %b data %h required 1 1 3b", res_valid, res_tag, res_data); end
    checks++; if (err_count !== W'(1)) begin errors++; $display("FAIL dec_err: got %0d required 1", err_count); end
    @(negedge clk);
  endtask
  task automatic test_tie;
    logic exp_dec;
    logic [6:0] exp_data;
    do_reset;
    enc_valid = 1'b1; dec_valid = 1'b1; res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_dec = 1'(k % 2);
      enc_data = 4'($urandom); dec_code = 7'($urandom);
      exp_data = exp_dec ? dec_ref(dec_code) : enc_of(enc_data);
      #1;
      checks++; if ({enc_ready, dec_ready} !== {~exp_dec, exp_dec}) begin errors++; $display("FAIL tie_grant %0d: readies %b required %b", k, {enc_ready, dec_ready}, {~exp_dec, exp_dec}); end
      @(negedge clk);
      #1;
      checks++; if ({enc_ready, dec_ready} !== 2'b00) begin errors++; $display("FAIL tie_exec_ready %0d: readies %b required 00", k, {enc_ready, dec_ready}); end
      @(negedge clk);
      checks++; if ({res_valid, res_tag, res_data} !== {1'b1, exp_dec, exp_data}) begin errors++; $display("FAIL tie_result %0d: valid %b tag %b data %h required 1 %b %h", k, res_valid, res_tag, res_data, exp_dec, exp_data); end
      @(negedge clk);
    end
    enc_valid = 1'b0; dec_valid = 1'b0;
  endtask
  task automatic test_backpressure;
    logic [6:0] exp_data;
    enc_data = 4'($urandom); enc_valid = 1'b1; res_ready = 1'b0;
    exp_data = enc_of(enc_data);
    @(negedge clk);
    dec_valid = 1'b1; dec_code = 7'($urandom);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({res_valid, res_data, enc_ready, dec_ready, busy} !== {1'b1, exp_data, 3'b001}) begin errors++; $display("FAIL bp_hold %0d: valid %b data %h readies %b busy %b required 1 %h 00 1", i, res_valid, res_data, {enc_ready, dec_ready}, busy, exp_data); end
      @(negedge clk);
    end
    res_ready = 1'b1; enc_valid = 1'b0; dec_valid = 1'b0;
    @(negedge clk);
    checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_release: res_valid,busy %b required 00", {res_valid, busy}); end
  endtask
  task automatic test_counter;
    logic [6:0] code;
    do_reset;
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      code = enc_of(4'($urandom)) ^ (7'd1 << $urandom_range(6, 0));
      dec_code = code; dec_valid = 1'b1;
      @(negedge clk);
      dec_valid = 1'b0;
      @(negedge clk);
      checks++; if (res_data !== dec_ref(code)) begin errors++; $display("FAIL cnt_data %0d: got %h required %h", i, res_data, dec_ref(code)); end
      checks++; if (err_count !== W'(i < 3 ? i + 1 : 3)) begin errors++; $display("FAIL cnt_sat %0d: got %0d required %0d", i, err_count, i < 3 ? i + 1 : 3); end
      @(negedge clk);
    end
    dec_code = enc_of(4'($urandom)) ^ 7'h10; dec_valid = 1'b1;
    @(negedge clk);
    dec_valid = 1'b0; err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if ({res_valid, err_count} !== {1'b1, W'(0)}) begin errors++; $display("FAIL cnt_clr_priority: valid %b err %0d required 1 0", res_valid, err_count); end
    @(negedge clk);
  endtask
  task automatic test_reset_midop;
    enc_data = 4'($urandom); enc_valid = 1'b1; res_ready = 1'b0;
    @(negedge clk);
    enc_valid = 1'b0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL midop_hold: res_valid %b required 1", res_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL midop_async: res_valid,busy %b required 00", {res_valid, busy}); end
    @(negedge clk);
    rst = 1'b0;
    enc_data = 4'b0000; enc_valid = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    enc_valid = 1'b0;
    @(negedge clk);
    checks++; if ({res_valid, res_tag, res_data} !== {2'b10, 7'h00}) begin errors++; $display("FAIL midop_after: valid %b tag %b data %h required 1 0 00", res_valid, res_tag, res_data); end
    @(negedge clk);
  endtask
  task automatic test_random;
    logic [W+11:0] got, exp;
    logic gd, m_ptr, m_tag, m_rv, m_rt;
    logic [6:0] m_op, m_rd;
    logic [W-1:0] m_err;
    int m_ph;
    do_reset;
    m_ph = 0; m_ptr = 1'b0; m_tag = 1'b0; m_rv = 1'b0; m_rt = 1'b0; m_op = '0; m_rd = '0; m_err = '0;
    for (int i = 0; i < 1500; i++) begin
      enc_valid = 1'($urandom); dec_valid = 1'($urandom);
      enc_data = 4'($urandom); dec_code = 7'($urandom);
      res_ready = $urandom_range(3, 0) != 0;
      err_clr = $urandom_range(15, 0) == 0;
      #1;
      gd = dec_valid && (!enc_valid || m_ptr);
      exp = {m_ph == 0 && enc_valid && !gd, m_ph == 0 && gd, m_ph != 0, m_rv, m_rt, m_rd, m_err};
      got = {enc_ready, dec_ready, busy, res_valid, res_tag, res_data, err_count};
      checks++; if (got !== exp) begin errors++; $display("FAIL random cycle %0d: got %h required %h", i, got, exp); end
      if (err_clr) m_err = '0;
      else if (m_ph == 1 && m_tag && syn_of(m_op) != 3'd0 && m_err != '1) m_err++;
      if (m_ph == 0) begin
        if (enc_valid || dec_valid) begin
          m_tag = gd; m_op = gd ? dec_code : {3'b000, enc_data}; m_ptr = !gd; m_ph = 1;
        end
      end else if (m_ph == 1) begin
        m_rd = m_tag ? dec_ref(m_op) : enc_of(m_op[3:0]); m_rt = m_tag; m_rv = 1'b1; m_ph = 2;
      end else if (res_ready) begin
        m_rv = 1'b0; m_ph = 0;
      end
      @(negedge clk);
    end
  endtask
  initial begin
    test_reset;
    test_encode;
    test_decode;
    test_tie;
    test_backpressure;
    test_counter;
    test_reset_midop;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
